// File: rtl/bc_msg_arbiter.sv
// Round-robin arbiter that shares the broadcast-message fabric between cores.
// Disabled cores are drained and counted; per-core sent counters feed the host status path.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int MSG_WIDTH     = 47,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_COUNT-1:0]           core_en,
    input  logic                            hold,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
    input  logic [CORE_COUNT-1:0]           s_valid,
    output logic [CORE_COUNT-1:0]           s_ready,
    output logic [MSG_WIDTH-1:0]            m_msg,
    output logic [CORE_ID_WIDTH-1:0]        m_src,
    output logic                            m_valid,
    input  logic [CORE_ID_WIDTH-1:0]        stat_sel,
    output logic [CNT_WIDTH-1:0]            stat_sent,
    output logic [15:0]                     stat_drop
);

    logic [CORE_COUNT-1:0][MSG_WIDTH-1:0] msg_arr;
    logic [CORE_COUNT-1:0]                req;
    logic [CORE_COUNT-1:0]                drained;
    logic [CORE_ID_WIDTH-1:0]             rr_ptr;
    logic [CORE_ID_WIDTH-1:0]             scan_idx;
    logic [CORE_ID_WIDTH-1:0]             grant_idx;
    logic                                 grant_valid;
    logic [CORE_ID_WIDTH:0]               drop_cnt;
    logic [16:0]                          drop_sum;
    logic [15:0]                          drop_next;
    logic [CNT_WIDTH-1:0]                 sent [CORE_COUNT];

    assign msg_arr = s_msg;
    assign req     = s_valid & core_en;
    assign drained = s_valid & ~core_en;

    // Scan upward from rr_ptr; the index width wraps naturally since CORE_COUNT is a power of two.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (!rst && !hold) begin
            for (int k = 0; k < CORE_COUNT; k++) begin
                scan_idx = rr_ptr + CORE_ID_WIDTH'(k);
                if (!grant_valid && req[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (!rst) begin
            s_ready = drained;
            if (grant_valid) begin
                s_ready[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            drop_cnt = drop_cnt + (CORE_ID_WIDTH + 1)'(drained[i]);
        end
        drop_sum  = {1'b0, stat_drop} + 17'(drop_cnt);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // stat_sent samples the counter before this cycle's increment lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_msg     <= '0;
            m_src     <= '0;
            rr_ptr    <= '0;
            stat_drop <= '0;
            stat_sent <= '0;
            for (int i = 0; i < CORE_COUNT; i++) begin
                sent[i] <= '0;
            end
        end else begin
            m_valid   <= grant_valid;
            stat_drop <= drop_next;
            stat_sent <= sent[stat_sel];
            if (grant_valid) begin
                m_msg           <= msg_arr[grant_idx];
                m_src           <= grant_idx;
                rr_ptr          <= grant_idx + CORE_ID_WIDTH'(1);
                sent[grant_idx] <= sent[grant_idx] + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Scoreboard bench for bc_msg_arbiter: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the arbitration rules.
module tb_bc_msg_arbiter;

    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int MW  = 47;
    localparam int CW  = 32;

    typedef struct {
        logic [MW-1:0] msg;
        int            src;
    } bc_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      core_en;
    logic              hold;
    logic [N*MW-1:0]   s_msg;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [MW-1:0]     m_msg;
    logic [IDW-1:0]    m_src;
    logic              m_valid;
    logic [IDW-1:0]    stat_sel;
    logic [CW-1:0]     stat_sent;
    logic [15:0]       stat_drop;

    bc_t               exp_q[$];
    bc_t               mon_item;
    int                checks = 0;
    int                errors = 0;
    int                model_ptr;
    longint            model_sent [N];
    int                model_drop;
    logic              use_fixed = 1'b0;
    logic [MW-1:0]     fixed_msg;

    always #5 clk = ~clk;

    bc_msg_arbiter #(
        .CORE_COUNT(N), .CORE_ID_WIDTH(IDW), .MSG_WIDTH(MW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .core_en(core_en), .hold(hold),
        .s_msg(s_msg), .s_valid(s_valid), .s_ready(s_ready),
        .m_msg(m_msg), .m_src(m_src), .m_valid(m_valid),
        .stat_sel(stat_sel), .stat_sent(stat_sent), .stat_drop(stat_drop)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict grant/ready, advance the model, then check the stats.
    task automatic applyStimulus(input logic r, input logic [N-1:0] en, input logic h,
                                 input logic [N-1:0] v, input logic [IDW-1:0] sel);
        logic [MW-1:0] msgs [N];
        logic [N-1:0]  exp_ready;
        longint        exp_stat;
        int            g;
        int            idx;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            msgs[i] = MW'({$urandom, $urandom});
        end
        if (use_fixed) msgs[3] = fixed_msg;
        for (int i = 0; i < N; i++) begin
            s_msg[i*MW +: MW] = msgs[i];
        end
        rst = r; core_en = en; hold = h; s_valid = v; stat_sel = sel;
        #1;
        g = -1;
        if (!r && !h) begin
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (g < 0 && v[idx] && en[idx]) g = idx;
            end
        end
        exp_ready = r ? '0 : (v & ~en);
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("s_ready", 64'(s_ready), 64'(exp_ready));
        exp_stat = r ? 0 : model_sent[sel];
        if (r) begin
            model_ptr  = 0;
            model_drop = 0;
            for (int i = 0; i < N; i++) model_sent[i] = 0;
        end else begin
            if (g >= 0) begin
                exp_q.push_back('{msg: msgs[g], src: g});
                model_ptr     = (g + 1) % N;
                model_sent[g] = (model_sent[g] + 1) & 64'hFFFF_FFFF;
            end
            model_drop = model_drop + $countones(v & ~en);
            if (model_drop > 65535) model_drop = 65535;
        end
        @(posedge clk);
        #1;
        checkOutput("stat_sent", 64'(stat_sent), 64'(exp_stat));
        checkOutput("stat_drop", 64'(stat_drop), 64'(model_drop));
    endtask

    // Monitor: every broadcast must match the oldest predicted grant, exactly one cycle later.
    always @(posedge clk) begin
        #1;
        checkOutput("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            mon_item = exp_q.pop_front();
            if (m_valid) begin
                checkOutput("m_src", 64'(m_src), 64'(mon_item.src));
                checkOutput("m_msg", 64'(m_msg), 64'(mon_item.msg));
            end
        end
    end

    initial begin
        rst = 1'b1; core_en = '1; hold = 1'b0; s_valid = '0; stat_sel = '0; s_msg = '0;
        model_ptr = 0; model_drop = 0;
        for (int i = 0; i < N; i++) model_sent[i] = 0;

        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        checkOutput("reset_m_msg", 64'(m_msg), 64'd0);
        checkOutput("reset_m_src", 64'(m_src), 64'd0);

        $display("[TB] single requester on core 3");
        fixed_msg = 47'h1_2345_6789_AB;
        use_fixed = 1'b1;
        applyStimulus(1'b0, '1, 1'b0, 8'h08, 3'd3);
        use_fixed = 1'b0;
        applyStimulus(1'b0, '1, 1'b0, 8'h00, 3'd3);
        applyStimulus(1'b0, '1, 1'b0, 8'h00, 3'd3);

        $display("[TB] all cores valid for 16 cycles");
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        for (int c = 0; c < 16; c++) applyStimulus(1'b0, '1, 1'b0, '1, '0);
        for (int i = 0; i < N; i++) applyStimulus(1'b0, '1, 1'b0, '0, IDW'(i));
        applyStimulus(1'b0, '1, 1'b0, '0, 3'd7);

        $display("[TB] cores 2 and 5 with pointer at 3");
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        applyStimulus(1'b0, '1, 1'b0, 8'h04, 3'd2);
        applyStimulus(1'b0, '1, 1'b0, 8'h24, 3'd5);
        applyStimulus(1'b0, '1, 1'b0, 8'h24, 3'd2);
        applyStimulus(1'b0, '1, 1'b0, 8'h18, 3'd3);

        $display("[TB] draining disabled core 4 up to saturation");
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        for (int c = 0; c < 70000; c++) applyStimulus(1'b0, 8'hEF, 1'b0, 8'h10, '0);

        $display("[TB] hold with cores 0 and 1 valid");
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, '1, 1'b1, 8'h03, '0);
        applyStimulus(1'b0, '1, 1'b0, 8'h03, '0);
        applyStimulus(1'b0, '1, 1'b1, 8'h03, '0);
        applyStimulus(1'b0, '1, 1'b0, 8'h03, 3'd1);

        $display("[TB] reset right after an accept on core 6");
        applyStimulus(1'b1, '1, 1'b0, '0, '0);
        applyStimulus(1'b0, '1, 1'b0, 8'h40, 3'd6);
        applyStimulus(1'b1, '1, 1'b0, 8'h40, 3'd6);
        applyStimulus(1'b0, '1, 1'b0, 8'h00, 3'd6);
        applyStimulus(1'b0, '1, 1'b0, 8'h01, 3'd6);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] en_r;
            en_r = N'($urandom) | N'($urandom) | N'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, en_r, $urandom_range(0, 9) == 0,
                          N'($urandom), IDW'($urandom));
        end

        applyStimulus(1'b0, '1, 1'b0, '0, '0);
        applyStimulus(1'b0, '1, 1'b0, '0, '0);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bc_msg_arbiter.md
Name: bc_msg_arbiter

Overview:
- Shares the single broadcast-message fabric between CORE_COUNT RISC-V core wrappers.
- Collects each core's bc_msg_out valid/ready stream and selects one message per cycle using round-robin.
- Registers the selected message and presents it as a one-cycle broadcast pulse, which fans out to every core's bc_msg_in. That input has no ready, so the output has no backpressure.
- Messages from cores held in reset are drained and counted. Per-core traffic counters are exposed for the host status path.

Parameters:
- CORE_COUNT, 8, number of requesting cores (power of two, ≥2).
- CORE_ID_WIDTH, $clog2(CORE_COUNT), width of the source index.
- MSG_WIDTH, 47, broadcast message width (32 data + 4 strobe + BC region address bits).
- CNT_WIDTH, 32, width of the per-core sent counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- core_en  in  CORE_COUNT  1 = core active. 0 = core in reset; its messages are drained and dropped.
- hold  in  1  1 = grant nothing (used during BC region reconfiguration). Disabled-core draining continues.
- s_msg  in  CORE_COUNT*MSG_WIDTH  per-core message; core i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- s_valid  in  CORE_COUNT  per-core message valid.
- s_ready  out  CORE_COUNT  per-core accept.
- m_msg  out  MSG_WIDTH  broadcast message.
- m_src  out  CORE_ID_WIDTH  index of the originating core.
- m_valid  out  1  single-cycle broadcast strobe.
- stat_sel  in  CORE_ID_WIDTH  counter select.
- stat_sent  out  CNT_WIDTH  sent count of the core selected by stat_sel.
- stat_drop  out  16  total dropped messages, saturating.

Behaviour:
- Reset (synchronous, rst=1):
  - m_valid=0, m_msg=0, m_src=0.
  - rr_ptr=0, all sent counters=0, stat_drop=0, stat_sent=0.
  - s_ready all 0 while rst is high.
- Request vector: req = s_valid & core_en.
- Grant (combinational, same cycle):
  - If hold=0 and req≠0, exactly one index g is granted: the first set bit of req scanning upward from rr_ptr, wrapping at CORE_COUNT-1 → 0.
  - If hold=1, nothing is granted.
- s_ready[i] = (i==g and grant valid) OR (core_en[i]==0 and s_valid[i]==1).
  - Disabled-core draining is independent of hold.
  - At most one enabled core is ready per cycle.
- Accept (handshake s_valid & s_ready on enabled core g):
  - Next cycle: m_valid=1, m_msg=s_msg[g], m_src=g.
  - rr_ptr <= (g+1) mod CORE_COUNT.
  - sent[g] increments by 1 and wraps at 2^CNT_WIDTH.
- Cycles with no accept: m_valid=0 on the next cycle. m_msg and m_src hold their last value. rr_ptr is unchanged.
- Latency is exactly 1 cycle from handshake to m_valid. Throughput is 1 message/cycle sustained. No internal buffering beyond the output register.
- Fairness: with all CORE_COUNT cores continuously valid, each core is granted exactly once every CORE_COUNT cycles.
- Drop counting:
  - Each cycle, stat_drop increases by popcount(s_valid & ~core_en) and saturates at 16'hFFFF.
  - A core whose core_en falls while its s_valid is high is drained that same cycle. It is never granted in that cycle.
- Simultaneous grant and core_en fall on the same core in the same cycle: core_en takes precedence, so the message is dropped, not broadcast.
- stat_sent is registered: stat_sent <= sent[stat_sel], giving 1-cycle read latency. A read and increment of the same counter in the same cycle returns the pre-increment value.
- hold asserted while m_valid=1: the in-flight message still broadcasts. hold only blocks new grants.
- rst asserted mid-stream: the message in the output register is discarded (m_valid=0 the next cycle), and rr_ptr returns to 0.

Test Plan:
- Single requester: core 3 valid with msg 0x1_2345_6789_AB, all cores enabled → s_ready[3]=1 in the same cycle; next cycle m_valid=1, m_src=3, m_msg matches; then stat_sel=3 → stat_sent=1.
- All 8 cores continuously valid for 16 cycles from reset → grant order 0,1,…,7,0,…,7; m_valid high every cycle after the first; every sent[i]=2.
- Cores 2 and 5 valid, rr_ptr=3 (after a grant to core 2) → core 5 granted first, then core 2; rr_ptr ends at 3.
- core_en[4]=0 with s_valid[4] held high for 10 cycles, no other traffic → s_ready[4]=1 each cycle, m_valid stays 0, stat_drop=10; after 70000 such cycles stat_drop=0xFFFF.
- hold=1 for 5 cycles with cores 0 and 1 valid → no s_ready and m_valid=0 throughout; after hold falls, core 0 is granted, then core 1 on the following cycle.
- Accept on core 6, then rst pulsed in the next cycle → m_valid=0 the cycle after rst; rr_ptr=0; sent[6]=0.
